// File: rtl/vis_pkg.sv
// Shared visualizer types and constants: screen geometry, datapath widths and
// the spawn-scheduler state encoding.
package vis_pkg;

  localparam int unsigned COORD_W  = 11;
  localparam int unsigned COLOR_W  = 8;
  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;

  // Plain constants keep the FSM register a legacy-compatible logic vector.
  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StPos    = 3'd1;
  localparam logic [2:0] StColor  = 3'd2;
  localparam logic [2:0] StWaitVb = 3'd3;
  localparam logic [2:0] StWrite  = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = StIdle,
    POS     = StPos,
    COLOR   = StColor,
    WAIT_VB = StWaitVb,
    WRITE   = StWrite
  } sched_state_t;

  typedef struct packed {
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } rgb_t;

  function automatic rgb_t rgb_halve(input rgb_t c);
    rgb_t h;
    h.r = c.r >> 1;
    h.g = c.g >> 1;
    h.b = c.b >> 1;
    return h;
  endfunction

endpackage

// File: rtl/circle_hue_ramp.sv
// Combinational hue ramp: maps an on-screen x coordinate to a saturated colour
// sweeping red -> green -> cyan-ish -> blue across the screen width.
module circle_hue_ramp
  import vis_pkg::*;
(
  input  logic [COORD_W-1:0] x_i,
  output logic [COLOR_W-1:0] r_o,
  output logic [COLOR_W-1:0] g_o,
  output logic [COLOR_W-1:0] b_o
);

  localparam logic [COORD_W-1:0] Q1   = COORD_W'(SCREEN_W / 4);
  localparam logic [COORD_W-1:0] Q2   = COORD_W'(SCREEN_W / 2);
  localparam logic [COORD_W-1:0] Q3   = COORD_W'((SCREEN_W * 3) / 4);
  localparam logic [COORD_W-1:0] Last = COORD_W'(SCREEN_W - 1);

  logic [1:0]         seg;
  logic [COORD_W-1:0] t;
  logic [13:0]        prod;
  logic [COLOR_W-1:0] ramp;

  always_comb begin
    seg = 2'd3;
    t   = Last - x_i;
    if (x_i < Q1) begin
      seg = 2'd0;
      t   = x_i;
    end else if (x_i < Q2) begin
      seg = 2'd1;
      t   = (Q2 - COORD_W'(1)) - x_i;
    end else if (x_i < Q3) begin
      seg = 2'd2;
      t   = x_i - Q2;
    end
  end

  // 51/32 ~= 255/160 scales a quarter-screen offset to a full colour swing.
  assign prod = 14'(t) * 14'd51;
  assign ramp = COLOR_W'(prod >> 5);

  always_comb begin
    r_o = '0;
    g_o = '0;
    b_o = '0;
    unique case (seg)
      2'd0: begin
        r_o = '1;
        g_o = ramp;
      end
      2'd1: begin
        r_o = ramp;
        g_o = '1;
      end
      2'd2: begin
        g_o = '1;
        b_o = ramp;
      end
      default: begin
        g_o = ramp;
        b_o = '1;
      end
    endcase
  end

endmodule

// File: rtl/circle_spawn_scheduler.sv
// Decides when and where a new circle spawns (audio beat or idle timeout),
// commits it to the circle table during vblank, and emits the decay tick.
module circle_spawn_scheduler
  import vis_pkg::*;
#(
  parameter int unsigned CIRNUM       = 25,
  parameter int unsigned DECAY_PERIOD = 1048576,
  parameter int unsigned IDLE_PERIOD  = 4194304,
  parameter int unsigned RAD_MIN      = 30
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_beat_valid,
  input  logic [7:0]                i_beat_level,
  output logic                      o_beat_ready,
  input  logic [25:0]               i_random,
  input  logic                      i_vblank,
  output logic                      o_wr_en,
  output logic [$clog2(CIRNUM)-1:0] o_wr_slot,
  output logic [COORD_W-1:0]        o_wr_x,
  output logic [COORD_W-1:0]        o_wr_y,
  output logic [COORD_W-1:0]        o_wr_rad,
  output logic [COLOR_W-1:0]        o_wr_r,
  output logic [COLOR_W-1:0]        o_wr_g,
  output logic [COLOR_W-1:0]        o_wr_b,
  output logic                      o_decay_tick
);

  localparam int unsigned SlotW  = $clog2(CIRNUM);
  localparam int unsigned DecayW = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
  localparam int unsigned IdleW  = (IDLE_PERIOD > 1) ? $clog2(IDLE_PERIOD) : 1;

  localparam logic [DecayW-1:0]  DecayLast = DecayW'(DECAY_PERIOD - 1);
  localparam logic [IdleW-1:0]   IdleLast  = IdleW'(IDLE_PERIOD - 1);
  localparam logic [SlotW-1:0]   SlotLast  = SlotW'(CIRNUM - 1);
  localparam logic [COORD_W-1:0] RadMin    = COORD_W'(RAD_MIN);

  logic [2:0]         state_q, state_d;
  logic [SlotW-1:0]   ptr_q, ptr_d;
  logic [IdleW-1:0]   idle_q, idle_d;
  logic [DecayW-1:0]  decay_q, decay_d;

  logic               src_idle_q;
  logic [5:0]         lvl_q;
  logic [24:0]        rnd_q;
  logic [COORD_W-1:0] x_q, y_q, rad_q;
  rgb_t               col_q;

  logic               wr_en_q;
  logic [SlotW-1:0]   wr_slot_q;
  logic [COORD_W-1:0] wr_x_q, wr_y_q, wr_rad_q;
  rgb_t               wr_col_q;

  logic               in_idle, beat_hs, idle_exp, start, commit, decay_hit;
  logic [9:0]         x_raw, x_fold;
  logic [8:0]         y_raw, y_fold;
  logic [COORD_W-1:0] rad_d;
  rgb_t               hue, col_d;
  logic               unused_bits;

  assign unused_bits = ^{i_random[25], i_beat_level[1:0]};

  assign in_idle   = (state_q == StIdle);
  assign beat_hs   = in_idle && i_beat_valid;
  assign idle_exp  = in_idle && (idle_q == IdleLast);
  // A beat and an idle expiry in the same cycle produce a single beat spawn.
  assign start     = beat_hs || idle_exp;
  assign commit    = (state_q == StWaitVb) && i_vblank;
  assign decay_hit = (decay_q == DecayLast);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (start) state_d = StPos;
      StPos:    state_d = StColor;
      StColor:  state_d = StWaitVb;
      StWaitVb: if (i_vblank) state_d = StWrite;
      StWrite:  state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == StWrite) begin
      ptr_d = (ptr_q == SlotLast) ? '0 : ptr_q + SlotW'(1);
    end
  end

  // Idle timer saturates at its last value while busy, so expiry fires on return to IDLE.
  always_comb begin
    if (start) begin
      idle_d = '0;
    end else if (idle_q == IdleLast) begin
      idle_d = idle_q;
    end else begin
      idle_d = idle_q + IdleW'(1);
    end
  end

  assign decay_d = decay_hit ? '0 : decay_q + DecayW'(1);

  // Fold out-of-range random coordinates back onto the visible area.
  assign x_raw  = rnd_q[9:0];
  assign y_raw  = rnd_q[18:10];
  assign x_fold = (x_raw >= 10'(SCREEN_W)) ? x_raw - 10'd512 : x_raw;
  assign y_fold = (y_raw >= 9'(SCREEN_H)) ? y_raw - 9'd256 : y_raw;
  assign rad_d  = src_idle_q ? RadMin + COORD_W'(rnd_q[24:19]) : RadMin + COORD_W'(lvl_q);

  circle_hue_ramp u_hue_ramp (
    .x_i (x_q),
    .r_o (hue.r),
    .g_o (hue.g),
    .b_o (hue.b)
  );

  assign col_d = src_idle_q ? rgb_halve(hue) : hue;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      idle_q     <= '0;
      decay_q    <= '0;
      src_idle_q <= 1'b0;
      lvl_q      <= '0;
      rnd_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      rad_q      <= '0;
      col_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_slot_q  <= '0;
      wr_x_q     <= '0;
      wr_y_q     <= '0;
      wr_rad_q   <= '0;
      wr_col_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idle_q  <= idle_d;
      decay_q <= decay_d;
      if (start) begin
        src_idle_q <= !beat_hs;
        lvl_q      <= i_beat_level[7:2];
        rnd_q      <= i_random[24:0];
      end
      if (state_q == StPos) begin
        x_q   <= COORD_W'(x_fold);
        y_q   <= COORD_W'(y_fold);
        rad_q <= rad_d;
      end
      if (state_q == StColor) begin
        col_q <= col_d;
      end
      wr_en_q <= commit;
      if (commit) begin
        wr_slot_q <= ptr_q;
        wr_x_q    <= x_q;
        wr_y_q    <= y_q;
        wr_rad_q  <= rad_q;
        wr_col_q  <= col_q;
      end
    end
  end

  assign o_beat_ready = in_idle;
  assign o_wr_en      = wr_en_q;
  assign o_wr_slot    = wr_slot_q;
  assign o_wr_x       = wr_x_q;
  assign o_wr_y       = wr_y_q;
  assign o_wr_rad     = wr_rad_q;
  assign o_wr_r       = wr_col_q.r;
  assign o_wr_g       = wr_col_q.g;
  assign o_wr_b       = wr_col_q.b;
  assign o_decay_tick = decay_hit;

endmodule

// File: tb/tb_circle_spawn_scheduler.sv
// Directed bench for circle_spawn_scheduler: beat and idle spawns, slot wrap,
// vblank stall, reset mid-spawn, beat/idle collision and decay tick cadence.
module tb_circle_spawn_scheduler;

  localparam int unsigned CIRNUM = 25;
  localparam int unsigned DECAY  = 8;
  localparam int unsigned IDLE   = 2048;
  localparam int unsigned RADMIN = 30;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_beat_valid;
  logic [7:0]  i_beat_level;
  logic        o_beat_ready;
  logic [25:0] i_random;
  logic        i_vblank;
  logic        o_wr_en;
  logic [4:0]  o_wr_slot;
  logic [10:0] o_wr_x, o_wr_y, o_wr_rad;
  logic [7:0]  o_wr_r, o_wr_g, o_wr_b;
  logic        o_decay_tick;

  int checks = 0;
  int errors = 0;

  circle_spawn_scheduler #(
    .CIRNUM       (CIRNUM),
    .DECAY_PERIOD (DECAY),
    .IDLE_PERIOD  (IDLE),
    .RAD_MIN      (RADMIN)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_beat_valid (i_beat_valid),
    .i_beat_level (i_beat_level),
    .o_beat_ready (o_beat_ready),
    .i_random     (i_random),
    .i_vblank     (i_vblank),
    .o_wr_en      (o_wr_en),
    .o_wr_slot    (o_wr_slot),
    .o_wr_x       (o_wr_x),
    .o_wr_y       (o_wr_y),
    .o_wr_rad     (o_wr_rad),
    .o_wr_r       (o_wr_r),
    .o_wr_g       (o_wr_g),
    .o_wr_b       (o_wr_b),
    .o_decay_tick (o_decay_tick)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_rand(input logic [9:0] x, input logic [8:0] y, input logic [5:0] r);
    i_random = {1'b0, r, y, x};
  endtask

  task automatic check_fields(input int slot, input int x, input int y, input int rad,
                              input int r, input int g, input int b);
    check("slot", o_wr_slot, slot);
    check("x", o_wr_x, x);
    check("y", o_wr_y, y);
    check("rad", o_wr_rad, rad);
    check("r", o_wr_r, r);
    check("g", o_wr_g, g);
    check("b", o_wr_b, b);
  endtask

  // Entered at a negedge in IDLE with vblank high; handshake at the next edge,
  // write visible after the third edge that follows; returns one cycle later.
  task automatic beat(input logic [7:0] lvl, input int slot, input int x, input int y,
                      input int rad, input int r, input int g, input int b);
    check("ready_idle", o_beat_ready, 1);
    i_beat_valid = 1'b1;
    i_beat_level = lvl;
    @(negedge i_clk);
    i_beat_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("ready_busy", o_beat_ready, 0);
      check("wr_early", o_wr_en, 0);
      @(negedge i_clk);
    end
    check("wr_en", o_wr_en, 1);
    check("ready_write", o_beat_ready, 0);
    check_fields(slot, x, y, rad, r, g, b);
    @(negedge i_clk);
    check("wr_pulse", o_wr_en, 0);
    check("x_hold", o_wr_x, x);
  endtask

  task automatic wait_write(input int limit, output int cycles);
    cycles = 0;
    while (o_wr_en !== 1'b1 && cycles < limit) begin
      @(negedge i_clk);
      cycles++;
    end
    check("wr_seen", o_wr_en, 1);
  endtask

  initial begin
    int cyc;
    int bad;
    logic [7:0] lvl;
    i_rst        = 1'b0;
    i_beat_valid = 1'b0;
    i_beat_level = '0;
    i_random     = '0;
    i_vblank     = 1'b1;
    #1 i_rst = 1'b1;
    @(negedge i_clk);
    check("rst_wr_en", o_wr_en, 0);
    check("rst_ready", o_beat_ready, 1);
    check("rst_tick", o_decay_tick, 0);
    check_fields(0, 0, 0, 0, 0, 0, 0);
    i_rst = 1'b0;

    // 26 back-to-back beats: first is the reference vector, slots wrap to 0.
    set_rand(10'd100, 9'd200, 6'd5);
    for (int i = 0; i < 26; i++) begin
      lvl = (i == 0) ? 8'h80 : 8'(i * 8);
      beat(lvl, i % 25, 100, 200, RADMIN + int'(lvl >> 2), 255, 159, 0);
    end

    // Stall in WAIT_VB for 1000 cycles, then release vblank.
    i_vblank = 1'b0;
    set_rand(10'd300, 9'd100, 6'd0);
    check("stall_ready", o_beat_ready, 1);
    i_beat_valid = 1'b1;
    i_beat_level = 8'hFC;
    @(negedge i_clk);
    i_beat_valid = 1'b0;
    bad = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge i_clk);
      if (o_wr_en !== 1'b0 || o_beat_ready !== 1'b0) bad++;
    end
    check("stall_quiet", bad, 0);
    i_vblank = 1'b1;
    @(negedge i_clk);
    check("stall_wr_en", o_wr_en, 1);
    check_fields(1, 300, 100, 93, 30, 255, 0);
    @(negedge i_clk);

    // Reset while waiting for vblank discards the spawn and rewinds the pointer.
    i_vblank = 1'b0;
    set_rand(10'd50, 9'd50, 6'd0);
    i_beat_valid = 1'b1;
    i_beat_level = 8'h10;
    @(negedge i_clk);
    i_beat_valid = 1'b0;
    repeat (4) @(negedge i_clk);
    check("wait_ready", o_beat_ready, 0);
    i_rst = 1'b1;
    #1;
    check("rst_mid_wr_en", o_wr_en, 0);
    check("rst_mid_ready", o_beat_ready, 1);
    check("rst_mid_x", o_wr_x, 0);
    @(negedge i_clk);
    i_rst    = 1'b0;
    i_vblank = 1'b1;
    bad = 0;
    repeat (5) begin
      @(negedge i_clk);
      if (o_wr_en !== 1'b0) bad++;
    end
    check("rst_no_write", bad, 0);
    set_rand(10'd100, 9'd200, 6'd5);
    beat(8'h80, 0, 100, 200, 62, 255, 159, 0);

    // Idle spawn: 2048 cycles after the previous write.
    set_rand(10'd700, 9'd500, 6'd10);
    wait_write(2200, cyc);
    check("idle_delay", cyc, 2047);
    check_fields(1, 188, 244, 40, 104, 127, 0);
    @(negedge i_clk);

    // Beat arrives in the exact cycle the idle timer expires.
    repeat (2043) @(negedge i_clk);
    set_rand(10'd100, 9'd200, 6'd5);
    beat(8'h40, 2, 100, 200, 46, 255, 159, 0);
    wait_write(2200, cyc);
    check("collide_delay", cyc, 2047);
    check_fields(3, 100, 200, 35, 127, 79, 0);
    @(negedge i_clk);

    // Decay cadence; a write is placed on the first tick.
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    repeat (3) @(negedge i_clk);
    set_rand(10'd100, 9'd200, 6'd5);
    i_beat_valid = 1'b1;
    i_beat_level = 8'h00;
    @(negedge i_clk);
    i_beat_valid = 1'b0;
    for (int j = 4; j < 48; j++) begin
      check("decay_tick", o_decay_tick, ((j % 8) == 7) ? 1 : 0);
      if (j == 7) begin
        check("tick_wr_en", o_wr_en, 1);
        check("tick_slot", o_wr_slot, 0);
        check("tick_rad", o_wr_rad, 30);
      end
      @(negedge i_clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
